// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// master drives fetch, flush and decode-ready; slave is the queue.
interface if_id_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush_i;
    logic            if_valid_i;
    logic [ILEN-1:0] if_inst_i;
    logic [XLEN-1:0] if_pc_i;
    logic            if_ready_o;
    logic            id_valid_o;
    logic [ILEN-1:0] id_inst_o;
    logic [XLEN-1:0] id_pc_o;
    logic            id_ready_i;
    logic [CW-1:0]   count_o;

    modport master (
        output flush_i, if_valid_i, if_inst_i, if_pc_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_inst_o, id_pc_o, count_o
    );

    modport slave (
        input  flush_i, if_valid_i, if_inst_i, if_pc_i, id_ready_i,
        output if_ready_o, id_valid_o, id_inst_o, id_pc_o, count_o
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry first-word-fall-through queue between fetch and decode.
// Outputs depend only on registered state; flush empties in one cycle.
module if_id_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ILEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_id_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ILEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Ready is based on stored state only, so a full queue rejects
    // pushes even when decode pops in the same cycle.
    assign bus.if_ready_o = ~full;
    assign bus.id_valid_o = ~empty;
    assign bus.count_o    = count;

    assign push = bus.if_valid_i & ~full & ~bus.flush_i;
    assign pop  = ~empty & bus.id_ready_i & ~bus.flush_i;

    // Head mux: present the canonical NOP with PC 0 when nothing is held.
    always_comb begin
        bus.id_inst_o = NOP_INST;
        bus.id_pc_o   = '0;
        if (!empty) begin
            bus.id_inst_o = mem_inst[rd_ptr];
            bus.id_pc_o   = mem_pc[rd_ptr];
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_inst[wr_ptr] <= bus.if_inst_i;
            mem_pc[wr_ptr]   <= bus.if_pc_i;
        end
    end

    // Pointer and occupancy update; reset beats flush beats handshakes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a reference queue is updated from
// the observed handshakes and every output is compared each cycle.
module tb_if_id_queue;
    localparam int              XLEN  = 32;
    localparam int              ILEN  = 32;
    localparam int              DEPTH = 4;
    localparam logic [ILEN-1:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   mon_en;
    entry_t sb [$];

    if_id_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) qif ();

    if_id_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NOP_INST(NOP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs with the model, then advance the model with this
    // cycle's handshakes as the edge will see them.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            bit do_push;
            bit do_pop;
            sz = sb.size();
            check("count", 64'(qif.count_o), 64'(sz));
            check("if_ready", 64'(qif.if_ready_o), 64'(sz != DEPTH));
            check("id_valid", 64'(qif.id_valid_o), 64'(sz != 0));
            if (sz == 0) begin
                check("nop_inst", 64'(qif.id_inst_o), 64'(NOP));
                check("nop_pc", 64'(qif.id_pc_o), 64'd0);
            end else begin
                check("head_inst", 64'(qif.id_inst_o), 64'(sb[0].inst));
                check("head_pc", 64'(qif.id_pc_o), 64'(sb[0].pc));
            end
            if (rst || qif.flush_i) begin
                sb.delete();
            end else begin
                do_pop  = (sz != 0) && qif.id_ready_i;
                do_push = qif.if_valid_i && (sz != DEPTH);
                if (do_pop) void'(sb.pop_front());
                if (do_push) sb.push_back({qif.if_pc_i, qif.if_inst_i});
            end
        end
    end

    task automatic cyc(input bit v, input logic [XLEN-1:0] pc,
                       input logic [ILEN-1:0] inst, input bit rdy,
                       input bit fl, input bit rs);
        qif.if_valid_i = v;
        qif.if_pc_i    = pc;
        qif.if_inst_i  = inst;
        qif.id_ready_i = rdy;
        qif.flush_i    = fl;
        rst            = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        check("drain_bound", 64'(sb.size()), 64'd0);
        idle(1'b1);
    endtask

    function automatic logic [ILEN-1:0] mk(input logic [XLEN-1:0] pc);
        return pc ^ 32'hABC00000;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;

        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("rst_valid", 64'(qif.id_valid_o), 64'd0);
        check("rst_inst", 64'(qif.id_inst_o), 64'h13);
        check("rst_pc", 64'(qif.id_pc_o), 64'd0);
        check("rst_ready", 64'(qif.if_ready_o), 64'd1);
        check("rst_count", 64'(qif.count_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'(i * 4), 32'(i * 4) | 32'h100000, 1'b1, 1'b0, 1'b0);
            check("stream_pc", 64'(qif.id_pc_o), 64'(i * 4));
            check("stream_cnt", 64'(qif.count_o), 64'd1);
        end
        drain();

        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'h100 + 32'(i * 4), mk(32'h100 + 32'(i * 4)),
                1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h110, mk(32'h110), 1'b0, 1'b0, 1'b0);
            check("full_cnt", 64'(qif.count_o), 64'd4);
            check("full_rdy", 64'(qif.if_ready_o), 64'd0);
            check("stall_head", 64'(qif.id_pc_o), 64'h100);
        end
        cyc(1'b1, 32'h110, mk(32'h110), 1'b1, 1'b0, 1'b0);
        check("full_pop_cnt", 64'(qif.count_o), 64'd3);
        check("full_pop_head", 64'(qif.id_pc_o), 64'h104);
        cyc(1'b1, 32'h110, mk(32'h110), 1'b1, 1'b0, 1'b0);
        check("wrap_cnt", 64'(qif.count_o), 64'd3);
        drain();

        cyc(1'b1, 32'h200, mk(32'h200), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, mk(32'h204), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, mk(32'h208), 1'b1, 1'b0, 1'b0);
        check("pp_cnt", 64'(qif.count_o), 64'd2);
        check("pp_head", 64'(qif.id_pc_o), 64'h204);
        idle(1'b1);
        check("pp_second", 64'(qif.id_pc_o), 64'h208);
        drain();

        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h300 + 32'(i * 4), mk(32'h300 + 32'(i * 4)),
                1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h30C, mk(32'h30C), 1'b1, 1'b1, 1'b0);
        check("fl_cnt", 64'(qif.count_o), 64'd0);
        check("fl_valid", 64'(qif.id_valid_o), 64'd0);
        check("fl_inst", 64'(qif.id_inst_o), 64'(NOP));
        cyc(1'b1, 32'h400, mk(32'h400), 1'b0, 1'b0, 1'b0);
        check("post_fl_pc", 64'(qif.id_pc_o), 64'h400);
        drain();

        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'h500 + 32'(i * 4), mk(32'h500 + 32'(i * 4)),
                1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h510, mk(32'h510), 1'b1, 1'b1, 1'b1);
        check("mrst_cnt", 64'(qif.count_o), 64'd0);
        check("mrst_rdy", 64'(qif.if_ready_o), 64'd1);
        check("mrst_inst", 64'(qif.id_inst_o), 64'(NOP));
        check("mrst_pc", 64'(qif.id_pc_o), 64'd0);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, 32'h600, mk(32'h600), 1'b1, 1'b0, 1'b0);
        check("mrst_new", 64'(qif.id_pc_o), 64'h600);
        drain();

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(i * 4),
                mk(32'h1000 + 32'(i * 4)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 40) == 0), 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry first-word-fall-through queue between fetch and decode with valid/ready handshakes on both sides. It decouples fetch from decode stalls, so fetch keeps running until the queue fills. It supports single-cycle flush on redirect and presents a canonical NOP whenever no valid instruction is held. It sits between the fetch unit and the decode stage, and is driven by the hazard/redirect logic.

## Interface
Parameters:
- XLEN, 32, width of PC.
- ILEN, 32, width of instruction word.
- DEPTH, 4, queue entries; power of two, ≥2.
- NOP_INST, 32'h00000013, word presented when empty (addi x0,x0,0).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held entries and any same-cycle push.
- if_valid_i  in  1  fetch offers an instruction.
- if_inst_i  in  ILEN  fetched instruction.
- if_pc_i  in  XLEN  PC of fetched instruction.
- if_ready_o  out  1  queue accepts a push this cycle.
- id_valid_o  out  1  head entry valid.
- id_inst_o  out  ILEN  head instruction, or NOP_INST when empty.
- id_pc_o  out  XLEN  head PC, or 0 when empty.
- id_ready_i  in  1  decode consumes head (i.e. not stalled).
- count_o  out  $clog2(DEPTH+1)  entries held.

## Operation
- Storage: DEPTH×(ILEN+XLEN) array, rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and a count register of $clog2(DEPTH+1) bits.
- push = if_valid_i & if_ready_o & ~flush_i; pop = id_valid_o & id_ready_i & ~flush_i.
- if_ready_o = (count != DEPTH). It is a function of registered state only, with no combinational path from id_ready_i. A full queue does not accept a push even when a pop occurs in the same cycle.
- id_valid_o = (count != 0). When valid, id_inst_o and id_pc_o come combinationally from mem[rd_ptr]. When empty, they are NOP_INST and 0.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal whenever 0 < count < DEPTH.
- Push to an empty queue: the entry becomes visible the next cycle. There is no same-cycle bypass.
- While id_ready_i is low, the head and all outputs hold stable. This is the equivalent of the old stall behaviour.
- flush_i has priority over push and pop. Next cycle: rd_ptr = wr_ptr = 0, count = 0, and outputs show empty/NOP. The fetch data offered in the flush cycle is dropped even if if_ready_o was high. Fetch treats a flush as a redirect.
- if_valid_i with if_ready_o low is not a handshake. Fetch holds its data, and the queue does not require that data to be stable.
- Memory contents are not reset. Only pointers and count are reset.

## Timing
- Reset (rst_i high at an edge): count_o = 0, if_ready_o = 1, id_valid_o = 0, id_inst_o = NOP_INST, id_pc_o = 0. Reset dominates flush_i and all handshakes. Reset asserted mid-stream discards all entries exactly as flush does.
- Latency: a push at edge N makes the entry available at the output during cycle N+1.
- Throughput: 1 instruction/cycle sustained with id_ready_i held high, for any DEPTH ≥ 2.
- Full at count == DEPTH: if_ready_o = 0 until the cycle after the first pop.
- Empty at count == 0: a pop is impossible. id_ready_i high has no effect.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Order is preserved across the wrap.
- Outputs are registered-state + mux only. No output depends combinationally on if_*_i or flush_i.

## Test plan
- Reset/empty:
  - Stimulus: assert rst_i 2 cycles, then release with no traffic.
  - Required: id_valid_o=0, id_inst_o=32'h00000013, id_pc_o=0, if_ready_o=1, count_o=0.
- Streaming:
  - Stimulus: id_ready_i=1; push PCs 0x0,0x4,…,0x1C on consecutive cycles, inst = PC|0x100000.
  - Required: each appears exactly one cycle after its push, in order; count_o stays at 1.
- Fill/stall/wrap (DEPTH=4):
  - Stimulus: id_ready_i=0, push 0x100,0x104,0x108,0x10C, then offer 0x110.
  - Required: count_o=4, if_ready_o=0, 0x110 not accepted, head 0x100 held stable.
  - Continuation: raise id_ready_i. Required: pops 0x100..0x10C, then 0x110 accepted after the wrap, with correct ordering.
- Simultaneous push/pop at count=2:
  - Stimulus: push and pop in the same cycle.
  - Required: count_o stays 2; the new entry is read after the two older ones.
- Flush:
  - Stimulus: with 3 entries held and a valid push offered, assert flush_i for one cycle.
  - Required: next cycle count_o=0, id_valid_o=0, id_inst_o=NOP_INST; the offered entry never appears. A push in the following cycle appears one cycle later.
- Reset mid-operation:
  - Stimulus: rst_i together with flush_i and push while the queue is full.
  - Required: identical to the reset state; no stale entry is emitted afterward.
